// File: rtl/logic_slice_engine_pkg.sv
// logic_slice_engine_pkg: shared op and FSM state encodings for the slice engine.
// Contents: op_e (AND/OR/XOR/XOR_ALT), state_e (IDLE/RUN/DONE).
package logic_slice_engine_pkg;

    typedef enum logic [1:0] {
        OP_AND     = 2'd0,
        OP_OR      = 2'd1,
        OP_XOR     = 2'd2,
        OP_XOR_ALT = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_slice_engine_logical_unit.sv
// logical_unit: combinational WIDTH-bit AND/OR/XOR unit.
// Ports: term0_i, term1_i operands; sel_i op select (0 AND, 1 OR, 2/3 XOR); result_o result.
module logical_unit
    import logic_slice_engine_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] term0_i,
    input  logic [WIDTH-1:0] term1_i,
    input  logic [1:0]       sel_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb
        result_o = (sel_i == OP_AND) ? (term0_i & term1_i) :
                   (sel_i == OP_OR)  ? (term0_i | term1_i) :
                                       (term0_i ^ term1_i);

endmodule

// File: rtl/logic_slice_engine.sv
// logic_slice_engine: multi-cycle AND/OR/XOR engine processing CHUNK-bit slices, LSB first.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_term0/req_term1/req_sel request
// channel; rsp_valid/rsp_ready/rsp_result response channel; busy while in RUN or DONE.
// Optional macro LOGIC_ZERO_FLAG_EN adds rsp_zero (result all-zero, valid with rsp_valid).
module logic_slice_engine
    import logic_slice_engine_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_term0,
    input  logic [WIDTH-1:0] req_term1,
    input  logic [1:0]       req_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
`ifdef LOGIC_ZERO_FLAG_EN
    output logic             rsp_zero,
`endif
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] t0_q, t1_q, res_q, res_d;
    logic [1:0]       sel_q;
    logic [CHUNK-1:0] slice_y;
    logic             accept;
`ifdef LOGIC_ZERO_FLAG_EN
    logic             nz_q, nz_d;
`endif

    assign accept = (state_q == IDLE) && req_valid;

    logical_unit #(.WIDTH(CHUNK)) u_lu (
        .term0_i  (t0_q[cnt_q*CHUNK +: CHUNK]),
        .term1_i  (t1_q[cnt_q*CHUNK +: CHUNK]),
        .sel_i    (sel_q),
        .result_o (slice_y)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
`ifdef LOGIC_ZERO_FLAG_EN
        nz_d    = nz_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = RUN;
                cnt_d   = '0;
                res_d   = '0;
`ifdef LOGIC_ZERO_FLAG_EN
                nz_d    = 1'b0;
`endif
            end
            RUN: begin
                res_d[cnt_q*CHUNK +: CHUNK] = slice_y;
`ifdef LOGIC_ZERO_FLAG_EN
                nz_d  = nz_q | (|slice_y);
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            sel_q   <= '0;
`ifdef LOGIC_ZERO_FLAG_EN
            nz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
`ifdef LOGIC_ZERO_FLAG_EN
            nz_q    <= nz_d;
`endif
            if (accept) begin
                t0_q  <= req_term0;
                t1_q  <= req_term1;
                sel_q <= req_sel;
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_result = res_q;
`ifdef LOGIC_ZERO_FLAG_EN
    // Gated with DONE so the flag reads 0 out of reset and between responses.
    assign rsp_zero   = (state_q == DONE) && !nz_q;
`endif

endmodule

// File: tb/tb_logic_slice_engine.sv
// tb_logic_slice_engine: directed self-checking bench for logic_slice_engine (WIDTH=32, CHUNK=8).
module tb_logic_slice_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_term0 = '0;
    logic [31:0] req_term1 = '0;
    logic [1:0]  req_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        busy;
`ifdef LOGIC_ZERO_FLAG_EN
    logic        rsp_zero;
`endif
    int total = 0;
    int bad = 0;
    int n;
    logic [31:0] held;

    always #5 clk = ~clk;

    logic_slice_engine #(.WIDTH(32), .CHUNK(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_term0  (req_term0),
        .req_term1  (req_term1),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
`ifdef LOGIC_ZERO_FLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        req_valid = 1'b1;
        req_term0 = a;
        req_term1 = b;
        req_sel   = s;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cnt);
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
`ifdef LOGIC_ZERO_FLAG_EN
        chk("rst_zero", {31'b0, rsp_zero}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

        send(32'hF0F0_1234, 32'hFF00_FF00, 2'd0);
        chk("and_busy", {31'b0, busy}, 32'd1);
        chk("and_req_ready_run", {31'b0, req_ready}, 32'd0);
        wait_rsp(n);
        chk("and_latency", n, 32'd4);
        chk("and_result", rsp_result, 32'hF000_1200);
        @(negedge clk);
        chk("and_req_ready_after", {31'b0, req_ready}, 32'd1);
        chk("and_rsp_valid_after", {31'b0, rsp_valid}, 32'd0);

        send(32'h0000_00FF, 32'h1200_0000, 2'd1);
        wait_rsp(n);
        chk("or_latency", n, 32'd4);
        chk("or_result", rsp_result, 32'h1200_00FF);
        @(negedge clk);

        send(32'hAAAA_AAAA, 32'hFFFF_FFFF, 2'd3);
        wait_rsp(n);
        chk("xor3_result", rsp_result, 32'h5555_5555);
        @(negedge clk);

`ifdef LOGIC_ZERO_FLAG_EN
        send(32'h1234_5678, 32'h1234_5678, 2'd2);
        wait_rsp(n);
        chk("zero_result", rsp_result, 32'd0);
        chk("zero_flag_set", {31'b0, rsp_zero}, 32'd1);
        @(negedge clk);
        send(32'h8000_0000, 32'h8000_0000, 2'd0);
        wait_rsp(n);
        chk("top_result", rsp_result, 32'h8000_0000);
        chk("zero_flag_clr", {31'b0, rsp_zero}, 32'd0);
        @(negedge clk);
`endif

        rsp_ready = 1'b0;
        send(32'h0F0F_0F0F, 32'h00FF_00FF, 2'd2);
        wait_rsp(n);
        chk("bp_result", rsp_result, 32'h0FF0_0FF0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_result_hold", rsp_result, 32'h0FF0_0FF0);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_term0 = 32'hFFFF_FFFF;
        req_term1 = 32'h0000_FFFF;
        req_sel   = 2'd0;
        @(negedge clk);
        req_term0 = 32'h0000_0000;
        req_term1 = 32'h1234_5678;
        req_sel   = 2'd1;
        @(negedge clk);
        chk("iso_req_ready_run", {31'b0, req_ready}, 32'd0);
        chk("iso_busy", {31'b0, busy}, 32'd1);
        wait_rsp(n);
        chk("iso_first_result", rsp_result, 32'h0000_FFFF);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("iso_idle_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("iso_second_busy", {31'b0, busy}, 32'd1);
        wait_rsp(n);
        chk("iso_second_latency", n, 32'd4);
        chk("iso_second_result", rsp_result, 32'h1234_5678);
        @(negedge clk);

        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h00FF_00FF, 32'hFF00_FF00, 2'd2);
        wait_rsp(n);
        chk("post_rst_latency", n, 32'd4);
        chk("post_rst_result", rsp_result, 32'hFFFF_FFFF);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/logic_slice_engine.md
# logic_slice_engine

Multi-cycle bitwise logic engine. It accepts an AND/OR/XOR request over a valid/ready request channel and returns the WIDTH-bit result over a valid/ready response channel. Operands are processed in CHUNK-bit slices, LSB slice first, through one CHUNK-wide `logical_unit` instance. It gives the datapath a flow-controlled, area-reduced front end to the combinational logic unit.

## Interface
- `WIDTH`, default 32: operand/result width; must be an integer multiple of `CHUNK`.
- `CHUNK`, default 8: slice width processed per cycle; N = WIDTH/CHUNK slices.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: engine can accept a request.
- `req_term0`  in  WIDTH: operand 0.
- `req_term1`  in  WIDTH: operand 1.
- `req_sel`  in  2: 0 = AND, 1 = OR, 2 or 3 = XOR.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer takes the result.
- `rsp_result`  out  WIDTH: operation result.
- `rsp_zero`  out  1: result is all-zero; present only with `LOGIC_ZERO_FLAG_EN`.
- `busy`  out  1: a request is in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`: capture the operands and `req_sel`, clear the result register, set slice counter=0, go to RUN.
- RUN:
  - Each cycle, compute slice[counter] = op(term0 slice, term1 slice) and write it into bits [counter*CHUNK +: CHUNK] of the result register.
  - Counter increments each cycle.
  - After the slice counter==N-1 write, go to DONE.
- DONE:
  - `rsp_valid`=1; `rsp_result` holds the full result.
  - On `rsp_ready`: go to IDLE.
- `req_ready` is 1 only in IDLE. Requests presented in RUN or DONE are not accepted and not lost; the requester keeps `req_valid` asserted.
- Captured operands are insensitive to input changes after the accept edge.
- sel=3 behaves identically to sel=2 (XOR).
- Counter width is clog2(N), minimum 1 bit. When N=1, RUN lasts one cycle.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - State goes to IDLE.
  - `req_ready`=1 after release; `rsp_valid`=0, `busy`=0, `rsp_result`=0, `rsp_zero`=0.
  - An in-flight operation is discarded.
- Accept at edge k: RUN spans N cycles; `rsp_valid` rises at edge k+N.
- Response handshake at edge m: `rsp_valid`=0 and `req_ready`=1 from edge m+1. Minimum request-to-request interval is N+2 cycles.
- `rsp_valid` and `rsp_result` (and `rsp_zero`) are held stable while `rsp_valid`=1 and `rsp_ready`=0, for an unlimited duration.
- `rsp_ready` asserted outside DONE is ignored.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Configuration
- `LOGIC_ZERO_FLAG_EN` defined:
  - `rsp_zero` port exists.
  - A sticky "nonzero" register is cleared on accept and ORs in the reduction of each computed slice.
  - `rsp_zero` = ~nonzero, valid with `rsp_valid`.
- Not defined: no `rsp_zero` port, no flag logic. All other behaviour is identical.

## Structure
- Shared package holds:
  - Op encodings: OP_AND=0, OP_OR=1, OP_XOR=2, OP_XOR_ALT=3.
  - FSM state encodings: IDLE, RUN, DONE.
- Sub-module: existing `logical_unit`, instantiated once with WIDTH=CHUNK, driven by the captured sel and the counter-selected operand slices.

## Test plan
(WIDTH=32, CHUNK=8)
- AND: 0xF0F0_1234 & 0xFF00_FF00, sel=0, `rsp_ready`=1 -> `rsp_valid` 4 cycles after accept, result 0xF000_1200, then `req_ready`=1 the next cycle.
- OR: 0x0000_00FF | 0x1200_0000, sel=1 -> 0x1200_00FF. XOR with sel=3: 0xAAAA_AAAA ^ 0xFFFF_FFFF -> 0x5555_5555.
- Zero flag (macro on): XOR of 0x1234_5678 with itself -> result 0, `rsp_zero`=1. AND 0x8000_0000 & 0x8000_0000 -> `rsp_zero`=0 (only the top slice is nonzero).
- Backpressure: hold `rsp_ready`=0 for 5 cycles in DONE -> `rsp_valid` and `rsp_result` constant, `req_ready`=0 throughout; assert `rsp_ready` -> IDLE next cycle.
- Input isolation: keep `req_valid`=1 with new operands during RUN -> not accepted until IDLE; changing `req_term0` after accept does not alter the first result.
- Reset mid-RUN (after slice 1): `rsp_valid`=0, `busy`=0, `rsp_result`=0 immediately; after release, a new request completes correctly.
